// File: rtl/core_run_ctrl.sv
// Run controller and self-check monitor for the single-cycle core: sequences
// the core reset, counts run cycles and ends the run with a single verdict.
module core_run_ctrl #(
    parameter int               WIDTH        = 32,
    parameter int               CNT_W        = 16,
    parameter int               RESET_CYCLES = 2,
    parameter int               MAX_CYCLES   = 100,
    parameter logic [WIDTH-1:0] MAILBOX_ADDR = 32'h0000_00FC,
    parameter logic [WIDTH-1:0] PASS_VALUE   = 32'h0000_0001,
    parameter int               HANG_CYCLES  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             mem_we,
    input  logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_wdata,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             hang,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [WIDTH-1:0] status_data
);

    localparam int               RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] HANG_LIM = CNT_W'(HANG_CYCLES);
    localparam logic             HANG_EN  = (HANG_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [RST_W-1:0] rst_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             pc_valid_r;
    logic [WIDTH-1:0] last_pc_r;

    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] stall_inc_s;
    logic             pc_same_s;
    logic             mbox_hit_s;
    logic             hang_hit_s;
    logic             tmo_hit_s;

    // Terminating-event decode for the current RUN cycle
    always_comb begin
        cnt_inc_s  = cycle_count + CNT_W'(1);
        pc_same_s  = pc_valid_r && (pc == last_pc_r);
        if (pc_same_s) begin
            stall_inc_s = stall_cnt_r + CNT_W'(1);
        end else begin
            stall_inc_s = {CNT_W{1'b0}};
        end
        mbox_hit_s = mem_we && (mem_addr == MAILBOX_ADDR);
        hang_hit_s = HANG_EN && pc_same_s && (stall_inc_s == HANG_LIM);
        tmo_hit_s  = (cnt_inc_s == MAX_LIM);
    end

    // Run-control FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RESET;
            core_rst    <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            hang        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= {CNT_W{1'b0}};
            status_data <= {WIDTH{1'b0}};
            rst_cnt_r   <= {RST_W{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
            pc_valid_r  <= 1'b0;
            last_pc_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_RESET: begin
                    core_rst <= 1'b1;
                    running  <= 1'b0;
                    done     <= 1'b0;
                    if (rst_cnt_r == RST_LAST) begin
                        state_r  <= ST_RUN;
                        core_rst <= 1'b0;
                        running  <= 1'b1;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + RST_W'(1);
                    end
                end
                ST_RUN: begin
                    last_pc_r   <= pc;
                    pc_valid_r  <= 1'b1;
                    stall_cnt_r <= stall_inc_s;
                    cycle_count <= cnt_inc_s;
                    // Mailbox beats hang beats timeout, so only one flag is ever set
                    if (mbox_hit_s) begin
                        status_data <= mem_wdata;
                        pass        <= (mem_wdata == PASS_VALUE);
                        fail        <= (mem_wdata != PASS_VALUE);
                    end else if (hang_hit_s) begin
                        hang <= 1'b1;
                    end else if (tmo_hit_s) begin
                        timeout <= 1'b1;
                    end else begin
                        status_data <= status_data;
                    end
                    if (mbox_hit_s || hang_hit_s || tmo_hit_s) begin
                        state_r  <= ST_DONE;
                        core_rst <= 1'b1;
                        running  <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        core_rst <= 1'b0;
                        running  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    core_rst <= 1'b1;
                    running  <= 1'b0;
                    done     <= 1'b1;
                end
                default: begin
                    state_r     <= ST_RESET;
                    core_rst    <= 1'b1;
                    running     <= 1'b0;
                    done        <= 1'b0;
                    pass        <= 1'b0;
                    fail        <= 1'b0;
                    hang        <= 1'b0;
                    timeout     <= 1'b0;
                    cycle_count <= {CNT_W{1'b0}};
                    status_data <= {WIDTH{1'b0}};
                    rst_cnt_r   <= {RST_W{1'b0}};
                    stall_cnt_r <= {CNT_W{1'b0}};
                    pc_valid_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: directed table of run scenarios,
// mid-run reset sequence and randomized runs scored against a run-level model.
module tb_core_run_ctrl;

    localparam int          MAXC = 100;
    localparam int          LMAX = 160;
    localparam logic [31:0] MB   = 32'h0000_00FC;
    localparam logic [31:0] PV   = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;

    logic        core_rst0, running0, done0, pass0, fail0, hang0, timeout0;
    logic [15:0] cycle_count0;
    logic [31:0] status_data0;
    logic        core_rst1, running1, done1, pass1, fail1, hang1, timeout1;
    logic [15:0] cycle_count1;
    logic [31:0] status_data1;

    logic [6:0] obs0, obs1;
    assign obs0 = {core_rst0, running0, done0, pass0, fail0, hang0, timeout0};
    assign obs1 = {core_rst1, running1, done1, pass1, fail1, hang1, timeout1};

    always #5 clk = ~clk;

    core_run_ctrl #(.WIDTH(32), .CNT_W(16), .RESET_CYCLES(2), .MAX_CYCLES(100),
                    .MAILBOX_ADDR(32'h0000_00FC), .PASS_VALUE(32'h0000_0001), .HANG_CYCLES(8)) u_dut0 (
        .clk(clk), .rst(rst), .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst0), .running(running0), .done(done0), .pass(pass0), .fail(fail0),
        .hang(hang0), .timeout(timeout0), .cycle_count(cycle_count0), .status_data(status_data0));

    core_run_ctrl #(.WIDTH(32), .CNT_W(16), .RESET_CYCLES(2), .MAX_CYCLES(100),
                    .MAILBOX_ADDR(32'h0000_00FC), .PASS_VALUE(32'h0000_0001), .HANG_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst1), .running(running1), .done(done1), .pass(pass1), .fail(fail1),
        .hang(hang1), .timeout(timeout1), .cycle_count(cycle_count1), .status_data(status_data1));

    int checks = 0;
    int failures = 0;

    // Per-RUN-cycle stimulus plan, index n = RUN cycle n
    logic [31:0] pc_a    [0:LMAX];
    logic        we_a    [0:LMAX];
    logic [31:0] addr_a  [0:LMAX];
    logic [31:0] wdata_a [0:LMAX];

    // Verdict codes: 0 pass, 1 fail, 2 hang, 3 timeout
    typedef struct {
        int          pc_hold;
        int          c1;
        logic [31:0] a1, d1;
        int          c2;
        logic [31:0] a2, d2;
        int          en0, ev0;
        logic [31:0] es0;
        int          en1, ev1;
        logic [31:0] es1;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Order: core_rst, running, done, pass, fail, hang, timeout
    function automatic logic [6:0] fin_flags(input int v);
        logic [6:0] f;
        f = 7'b1010000;
        case (v)
            0:       f[3] = 1'b1;
            1:       f[2] = 1'b1;
            2:       f[1] = 1'b1;
            default: f[0] = 1'b1;
        endcase
        return f;
    endfunction

    // Run-level reference: first mailbox store, else first run of HC+1 equal PCs, else budget
    function automatic void model(input int hc, output int en, output int ev, output logic [31:0] es);
        int runlen;
        bit hit;
        en = MAXC; ev = 3; es = 32'h0; runlen = 0; hit = 1'b0;
        for (int n = 1; n <= MAXC && !hit; n++) begin
            runlen = (n > 1 && pc_a[n] == pc_a[n-1]) ? runlen + 1 : 1;
            if (we_a[n] && addr_a[n] == MB) begin
                en = n; ev = (wdata_a[n] == PV) ? 0 : 1; es = wdata_a[n]; hit = 1'b1;
            end else if (hc != 0 && runlen == hc + 1) begin
                en = n; ev = 2; hit = 1'b1;
            end
        end
    endfunction

    task automatic do_reset(input string tag);
        mem_we = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "/rst_flags"}, {25'h0, obs0}, 32'h40);
        chk({tag, "/rst_cnt"}, {16'h0, cycle_count0}, 32'h0);
        chk({tag, "/rst_status"}, status_data0, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk({tag, "/hold1_flags"}, {25'h0, obs0}, 32'h40);
        @(posedge clk); #1;
        chk({tag, "/run_entry0"}, {25'h0, obs0}, 32'h20);
        chk({tag, "/run_entry1"}, {25'h0, obs1}, 32'h20);
        chk({tag, "/run_entry_cnt"}, {16'h0, cycle_count0}, 32'h0);
    endtask

    task automatic fill_base(input int hold);
        for (int n = 0; n <= LMAX; n++) begin
            pc_a[n]    = (hold != 0) ? 32'h20 : 32'h100 + 32'(4 * n);
            we_a[n]    = 1'b0;
            addr_a[n]  = 32'h200 + 32'(n);
            wdata_a[n] = 32'(n);
        end
    endtask

    task automatic run_plan(input string tag, input int en0, input int ev0, input logic [31:0] es0,
                            input int en1, input int ev1, input logic [31:0] es1);
        int last;
        int len;
        last = (en0 > en1) ? en0 : en1;
        len  = last + 20;
        for (int n = last + 1; n <= len; n++) begin
            pc_a[n] = $urandom; we_a[n] = 1'b1; addr_a[n] = MB; wdata_a[n] = $urandom;
        end
        do_reset(tag);
        for (int n = 1; n <= len; n++) begin
            pc = pc_a[n]; mem_we = we_a[n]; mem_addr = addr_a[n]; mem_wdata = wdata_a[n];
            @(posedge clk); #1;
            if (n == en0 - 1) chk({tag, "/pre0"}, {25'h0, obs0}, 32'h20);
            if (n == en1 - 1) chk({tag, "/pre1"}, {25'h0, obs1}, 32'h20);
            if (n == en0 || n == len) begin
                chk({tag, "/flags0"}, {25'h0, obs0}, {25'h0, fin_flags(ev0)});
                chk({tag, "/count0"}, {16'h0, cycle_count0}, 32'(en0));
                chk({tag, "/status0"}, status_data0, es0);
            end
            if (n == en1 || n == len) begin
                chk({tag, "/flags1"}, {25'h0, obs1}, {25'h0, fin_flags(ev1)});
                chk({tag, "/count1"}, {16'h0, cycle_count1}, 32'(en1));
                chk({tag, "/status1"}, status_data1, es1);
            end
        end
        mem_we = 1'b0;
    endtask

    initial begin
        int en0, ev0, en1, ev1;
        logic [31:0] es0, es1;
        int hs, hl, c;

        tbl[0] = '{0, 10, MB, PV, 0, 32'h0, 32'h0, 10, 0, PV, 10, 0, PV};
        tbl[1] = '{0, 5, 32'hF8, 32'hDEAD, 6, MB, 32'hDEAD, 6, 1, 32'hDEAD, 6, 1, 32'hDEAD};
        tbl[2] = '{1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 9, 2, 32'h0, 100, 3, 32'h0};
        tbl[3] = '{0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 100, 3, 32'h0, 100, 3, 32'h0};
        tbl[4] = '{0, 100, MB, PV, 0, 32'h0, 32'h0, 100, 0, PV, 100, 0, PV};

        for (int i = 0; i < 5; i++) begin
            fill_base(tbl[i].pc_hold);
            if (tbl[i].c1 != 0) begin
                we_a[tbl[i].c1] = 1'b1; addr_a[tbl[i].c1] = tbl[i].a1; wdata_a[tbl[i].c1] = tbl[i].d1;
            end
            if (tbl[i].c2 != 0) begin
                we_a[tbl[i].c2] = 1'b1; addr_a[tbl[i].c2] = tbl[i].a2; wdata_a[tbl[i].c2] = tbl[i].d2;
            end
            run_plan($sformatf("tbl%0d", i), tbl[i].en0, tbl[i].ev0, tbl[i].es0,
                     tbl[i].en1, tbl[i].ev1, tbl[i].es1);
        end

        // Reset asserted in RUN cycle 40, then the reset sequence must repeat
        fill_base(0);
        do_reset("mid");
        for (int n = 1; n <= 40; n++) begin
            pc = pc_a[n]; mem_we = 1'b0; mem_addr = addr_a[n]; mem_wdata = wdata_a[n];
            if (n == 40) rst = 1'b1;
            @(posedge clk); #1;
            if (n == 39) chk("mid/count39", {16'h0, cycle_count0}, 32'd39);
        end
        chk("mid/flags0", {25'h0, obs0}, 32'h40);
        chk("mid/flags1", {25'h0, obs1}, 32'h40);
        chk("mid/count", {16'h0, cycle_count0}, 32'h0);
        do_reset("mid_again");

        for (int r = 0; r < 8; r++) begin
            hs = $urandom_range(2, 90);
            hl = $urandom_range(2, 14);
            for (int n = 0; n <= LMAX; n++) begin
                if (n == 0) pc_a[n] = 32'h1000;
                else if (n >= hs && n < hs + hl) pc_a[n] = pc_a[n-1];
                else pc_a[n] = pc_a[n-1] + (($urandom_range(0, 4) == 0) ? 32'd0 : 32'd4);
                we_a[n] = ($urandom_range(0, 15) == 0);
                addr_a[n] = ($urandom_range(0, 3) == 0) ? MB : 32'hF8;
                wdata_a[n] = $urandom;
            end
            c = $urandom_range(1, 115);
            we_a[c] = 1'b1;
            addr_a[c] = ($urandom_range(0, 2) == 0) ? 32'hF8 : MB;
            wdata_a[c] = ($urandom_range(0, 1) == 0) ? PV : $urandom;
            model(8, en0, ev0, es0);
            model(0, en1, ev1, es1);
            run_plan($sformatf("rnd%0d", r), en0, ev0, es0, en1, ev1, es1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
